// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb_pkg
//   Shared types and helpers for the FIFO write-port arbiter.
//   - arb_state_e   : arbiter FSM states (IDLE, BURST)
//   - DEF_NUM_REQ   : default requester count
//   - DEF_MAX_BURST : default maximum beats per grant
//   - id_w(n)       : index width for n items ($clog2, never below 1 bit)
// ---------------------------------------------------------------------------
package fifo_wr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 8;

    // Floors at one bit so a single-entry index still has a legal width.
    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the requester streams and the FIFO write side seen by the
//   arbiter.
//   Requester side : req_valid, req_data (packed, requester i at
//                    [i*DATA_WIDTH +: DATA_WIDTH]), req_last, req_ready
//   FIFO side      : wdata, write_enable, wfull, wr_almost_ful, overflow
//   Modports:
//     master - the arbiter (drives req_ready, wdata, write_enable)
//     slave  - the environment (requesters and FIFO)
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         wdata;
    logic                          write_enable;
    logic                          wfull;
    logic                          wr_almost_ful;
    logic                          overflow;

    modport master (
        input  req_valid, req_data, req_last, wfull, wr_almost_ful, overflow,
        output req_ready, wdata, write_enable
    );

    modport slave (
        output req_valid, req_data, req_last, wfull, wr_almost_ful, overflow,
        input  req_ready, wdata, write_enable
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. The request vector is doubled and all
//   positions below the start pointer are masked off, so the lowest set bit
//   of the masked vector is the first requester at or after start, with
//   wrap-around handled by the upper copy.
//   Ports:
//     req     in  N      request vector
//     start   in  IW     highest-priority index
//     grant   out N      one-hot winner (zero when no request)
//     winner  out IW     winner index (zero when no request)
//     any_req out 1      at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter  int N  = DEF_NUM_REQ,
    localparam int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;

    always_comb begin
        dbl = {req, req};
        for (int i = 0; i < 2*N; i++) begin
            mask[i] = (i >= int'(start));
        end
        masked = dbl & mask;

        // Scan downward so the lowest set position is the last one written.
        winner = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (masked[i]) begin
                winner = IW'(i % N);
            end
        end

        any_req = |req;
        grant   = any_req ? (N'(1) << winner) : '0;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the async-FIFO write port among NUM_REQ requesters with
//   round-robin burst arbitration in the wclk domain. An IDLE cycle picks
//   the next grantee (never while wr_almost_ful is high); BURST then passes
//   the grantee's beats straight through to the FIFO, stalling on wfull.
//   A burst ends on an accepted last beat, on the MAX_BURST-th accepted
//   beat, or when the grantee drops req_valid.
//
//   Ports:
//     wclk        in   write-domain clock
//     hw_rst_n    in   asynchronous active-low reset
//     bus         if   fifo_wr_arbiter_if.master (requester + FIFO signals)
//     grant_id    out  current grantee, valid while busy
//     busy        out  burst in progress
//   Optional (macro FIFO_WR_ARB_OVF_TRACK_EN):
//     ovf_sticky  out  set by the first overflow pulse after reset
//     ovf_id      out  grant_id captured with that first pulse
//   Without the macro the overflow input is ignored.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = DEF_MAX_BURST,
    localparam int IDW        = id_w(NUM_REQ)
) (
    input  logic              wclk,
    input  logic              hw_rst_n,
    fifo_wr_arbiter_if.master bus,
    output logic [IDW-1:0]    grant_id,
    output logic              busy
`ifdef FIFO_WR_ARB_OVF_TRACK_EN
    ,
    output logic              ovf_sticky,
    output logic [IDW-1:0]    ovf_id
`endif
);

    localparam int CNTW = id_w(MAX_BURST);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(MAX_BURST - 1);

    arb_state_e            state;
    logic [IDW-1:0]        rr_ptr;
    logic [CNTW-1:0]       beat_cnt;

    logic [NUM_REQ-1:0]    grant_onehot_unused;
    logic [IDW-1:0]        rr_winner;
    logic                  any_req;

    logic                  in_burst;
    logic                  g_valid;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  we;
    logic                  burst_end;
    logic [IDW-1:0]        next_ptr;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req     (bus.req_valid),
        .start   (rr_ptr),
        .grant   (grant_onehot_unused),
        .winner  (rr_winner),
        .any_req (any_req)
    );

    // Grantee mux: select valid/last/data of the registered grant_id.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                g_valid = bus.req_valid[i];
                g_last  = bus.req_last[i];
                g_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign in_burst = (state == BURST);
    assign we       = in_burst & g_valid & ~bus.wfull;

    // A dropped valid closes the burst even while wfull stalls it.
    assign burst_end = in_burst &
                       (~g_valid | (we & (g_last | (beat_cnt == LAST_CNT))));

    assign next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    assign bus.write_enable = we;
    assign bus.wdata        = we ? g_data : '0;
    assign bus.req_ready    = (in_burst & ~bus.wfull) ? (NUM_REQ'(1) << grant_id) : '0;

    always_ff @(posedge wclk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req && !bus.wr_almost_ful) begin
                        grant_id <= rr_winner;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (we) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (burst_end) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_OVF_TRACK_EN
    // Only the first overflow after reset is recorded; later pulses are ignored.
    always_ff @(posedge wclk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_id     <= '0;
        end else if (bus.overflow && !ovf_sticky) begin
            ovf_sticky <= 1'b1;
            ovf_id     <= grant_id;
        end
    end
`else
    logic overflow_unused;
    assign overflow_unused = bus.overflow;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Scoreboard bench for fifo_wr_arbiter. Requester beat lists are loaded
//   per test; the expected FIFO write sequence (grantee + data) is queued as
//   the stimulus is set up and checked against every write_enable cycle.
//   Optional overflow tracking is covered when FIFO_WR_ARB_OVF_TRACK_EN is
//   defined.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    logic       wclk;
    logic       rst_n;
    logic [1:0] grant_id;
    logic       busy;
`ifdef FIFO_WR_ARB_OVF_TRACK_EN
    logic       ovf_sticky;
    logic [1:0] ovf_id;
`endif

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (8)
    ) dut (
        .wclk       (wclk),
        .hw_rst_n   (rst_n),
        .bus        (bus.master),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef FIFO_WR_ARB_OVF_TRACK_EN
        ,
        .ovf_sticky (ovf_sticky),
        .ovf_id     (ovf_id)
`endif
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester beat storage: head owned by the driver, tail by the main flow.
    logic [DW-1:0] bdata [NR][64];
    logic          blast [NR][64];
    int            head  [NR];
    int            tail  [NR];

    exp_t sb[$];

    int cyc        = 0;
    int wr_n       = 0;
    int wr_cyc [256];
    int stall_cyc  = 0;
    int stall_viol = 0;

    task automatic load(input int id, input logic [DW-1:0] base, input int n, input int blen);
        for (int k = 0; k < n; k++) begin
            bdata[id][tail[id]] = base + DW'(k);
            blast[id][tail[id]] = (blen != 0) && (((k + 1) % blen) == 0);
            tail[id]++;
        end
    endtask

    task automatic expect_wr(input int id, input logic [DW-1:0] base, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.id   = 2'(id);
            e.data = base + DW'(k);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic wait_writes(input string tag, input int b, input int n, input int budget);
        int k = 0;
        while (wr_n < b + n && k < budget) begin
            @(negedge wclk);
            #1;
            k++;
        end
        check(tag, wr_n - b, n);
    endtask

    task automatic do_reset();
        @(posedge wclk);
        #1;
        rst_n             = 1'b0;
        bus.wfull         = 1'b0;
        bus.wr_almost_ful = 1'b0;
        bus.overflow      = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Requester driver: presents the head beat of each list, advances on an
    // accepted handshake, and discards pending beats while reset is held.
    initial begin
        logic [NR-1:0] acc;
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge wclk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge wclk);
            #2;
            for (int i = 0; i < NR; i++) begin
                if (!rst_n)      head[i] = tail[i];
                else if (acc[i]) head[i]++;
                if (head[i] < tail[i]) begin
                    bus.req_valid[i]            = 1'b1;
                    bus.req_last[i]             = blast[i][head[i]];
                    bus.req_data[i*DW +: DW]    = bdata[i][head[i]];
                end else begin
                    bus.req_valid[i]            = 1'b0;
                    bus.req_last[i]             = 1'b0;
                    bus.req_data[i*DW +: DW]    = '0;
                end
            end
        end
    end

    // FIFO-side monitor: every write is popped against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge wclk);
            cyc++;
            if (bus.wfull) begin
                stall_cyc++;
                if (bus.write_enable || (|bus.req_ready)) stall_viol++;
            end
            if (bus.write_enable) begin
                if (sb.size() == 0) begin
                    check("unexpected_wr", {32'h0, bus.wdata}, 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check("wr_data", bus.wdata, e.data);
                    check("wr_id", grant_id, e.id);
                end
                check("busy_on_wr", busy, 1);
                if (wr_n < 256) wr_cyc[wr_n] = cyc;
                wr_n++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int s0;
        int c0;
        rst_n             = 1'b0;
        bus.wfull         = 1'b0;
        bus.wr_almost_ful = 1'b0;
        bus.overflow      = 1'b0;
        repeat (3) @(posedge wclk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_we", bus.write_enable, 0);
        check("rst_ready", bus.req_ready, 0);
        check("rst_wdata", bus.wdata, 0);

        // Single requester, 3-beat burst.
        do_reset();
        b = wr_n;
        load(0, 32'hA0, 3, 3);
        expect_wr(0, 32'hA0, 3);
        wait_writes("single_cnt", b, 3, 20);
        check("single_gap1", wr_cyc[b+1] - wr_cyc[b], 1);
        check("single_gap2", wr_cyc[b+2] - wr_cyc[b+1], 1);
        @(negedge wclk);
        #1;
        check("single_busy_drop", busy, 0);

        // Fairness among requesters 0, 1, 3 with 2-beat bursts.
        do_reset();
        b = wr_n;
        load(0, 32'h10, 4, 2);
        load(1, 32'h20, 4, 2);
        load(3, 32'h30, 4, 2);
        expect_wr(0, 32'h10, 2);
        expect_wr(1, 32'h20, 2);
        expect_wr(3, 32'h30, 2);
        expect_wr(0, 32'h12, 2);
        expect_wr(1, 32'h22, 2);
        expect_wr(3, 32'h32, 2);
        wait_writes("fair_cnt", b, 12, 100);
        for (int j = 1; j < 12; j++) begin
            check("fair_gap", wr_cyc[b+j] - wr_cyc[b+j-1], (j % 2 == 0) ? 2 : 1);
        end

        // MAX_BURST cap: 12 beats without last from requester 2.
        do_reset();
        b = wr_n;
        load(2, 32'hC00, 12, 0);
        expect_wr(2, 32'hC00, 12);
        wait_writes("cap_cnt", b, 12, 100);
        for (int j = 1; j < 12; j++) begin
            check("cap_gap", wr_cyc[b+j] - wr_cyc[b+j-1], (j == 8) ? 2 : 1);
        end
        @(negedge wclk);
        @(negedge wclk);
        #1;
        check("cap_busy_end", busy, 0);

        // wfull stall for 3 cycles after the first beat of a 4-beat burst.
        do_reset();
        b  = wr_n;
        s0 = stall_viol;
        c0 = stall_cyc;
        load(0, 32'h400, 4, 4);
        expect_wr(0, 32'h400, 4);
        wait_writes("stall_first", b, 1, 20);
        @(posedge wclk);
        #1;
        bus.wfull = 1'b1;
        tick();
        tick();
        tick();
        bus.wfull = 1'b0;
        wait_writes("stall_cnt", b, 4, 20);
        check("stall_gap1", wr_cyc[b+1] - wr_cyc[b], 4);
        check("stall_gap2", wr_cyc[b+2] - wr_cyc[b+1], 1);
        check("stall_gap3", wr_cyc[b+3] - wr_cyc[b+2], 1);
        check("stall_cycles", stall_cyc - c0, 3);
        check("stall_viol", stall_viol - s0, 0);

        // Almost full blocks the grant in IDLE, not an active burst.
        do_reset();
        b = wr_n;
        bus.wr_almost_ful = 1'b1;
        load(1, 32'h500, 3, 3);
        expect_wr(1, 32'h500, 3);
        repeat (4) tick();
        check("af_hold_busy", busy, 0);
        check("af_hold_wr", wr_n - b, 0);
        bus.wr_almost_ful = 1'b0;
        @(negedge wclk);
        #1;
        check("af_idle_cycle", busy, 0);
        @(negedge wclk);
        #1;
        check("af_granted", busy, 1);
        check("af_grant_id", grant_id, 1);
        check("af_we", bus.write_enable, 1);
        @(posedge wclk);
        #1;
        bus.wr_almost_ful = 1'b1;
        wait_writes("af_cnt", b, 3, 20);
        check("af_gap1", wr_cyc[b+1] - wr_cyc[b], 1);
        check("af_gap2", wr_cyc[b+2] - wr_cyc[b+1], 1);
        bus.wr_almost_ful = 1'b0;

        // Reset mid-burst, then restart from requester 0.
        do_reset();
        b = wr_n;
        load(1, 32'hD0, 4, 4);
        expect_wr(1, 32'hD0, 1);
        wait_writes("mid_first", b, 1, 20);
        @(posedge wclk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_busy", busy, 0);
        check("mid_grant", grant_id, 0);
        check("mid_we", bus.write_enable, 0);
        check("mid_ready", bus.req_ready, 0);
        check("mid_wdata", bus.wdata, 0);
        tick();
        tick();
        rst_n = 1'b1;
        b = wr_n;
        load(0, 32'hE0, 2, 2);
        load(1, 32'hD0, 4, 4);
        expect_wr(0, 32'hE0, 2);
        expect_wr(1, 32'hD0, 4);
`ifdef FIFO_WR_ARB_OVF_TRACK_EN
        check("ovf_rst", ovf_sticky, 0);
        wait_writes("ovf_pre", b, 3, 40);
        @(posedge wclk);
        #1;
        bus.overflow = 1'b1;
        tick();
        bus.overflow = 1'b0;
        check("ovf_sticky", ovf_sticky, 1);
        check("ovf_id", ovf_id, 1);
`endif
        wait_writes("mid_restart_cnt", b, 6, 60);
        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
